// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: single-cycle memory-mapped request/response bus for the UART transmitter.
//   mem_valid  request strobe (master -> slave)
//   mem_addr   byte address; the slave decodes [3:0]
//   mem_wdata  write data
//   mem_wstrb  byte strobes; nonzero = write, zero = read
//   mem_rdata  read data, valid while mem_ready=1 (slave -> master)
//   mem_ready  one-cycle response strobe (slave -> master)
interface uart_tx_ctrl_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb, input mem_rdata, mem_ready);
    modport slave  (input mem_valid, mem_addr, mem_wdata, mem_wstrb, output mem_rdata, mem_ready);
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: memory-mapped 8N1 UART transmitter with a transmit FIFO and a drain interrupt.
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     slave side of the request/response bus (0x0 data/status, 0x8 irq enable)
//   tx_o    serial output, idle high, LSB first
//   irq_o   level interrupt: enabled, FIFO empty and shifter idle
module uart_tx_ctrl #(
    parameter int clk_divider_bit = 8680,
    parameter int fifo_depth      = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    uart_tx_ctrl_if.slave  bus,
    output logic           tx_o,
    output logic           irq_o
);
    localparam int aw = $clog2(fifo_depth);
    localparam int cw = $clog2(clk_divider_bit);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t        state_q;
    logic [cw-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;
    logic [7:0]    fifo_q [fifo_depth];
    logic [aw-1:0] rd_ptr_q, wr_ptr_q;
    logic [aw:0]   count_q, count_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_data_q, push_data;
    logic          ready_q, ready_d;
    logic [31:0]   rdata_q, rdata_d, rd_val;
    logic          irq_en_q, irq_en_d, irq_q, irq_d;
    logic          sel_data, sel_irq, is_wr, data_wr;
    logic          fifo_empty, fifo_full, busy, pop, push_req, push, cnt_last;
    logic          unused_bits;
    assign unused_bits = ^{bus.mem_addr[31:4], bus.mem_wdata[31:8]};
    always_comb begin
        sel_data   = bus.mem_addr[3:0] == 4'h0;
        sel_irq    = bus.mem_addr[3:0] == 4'h8;
        is_wr      = |bus.mem_wstrb;
        data_wr    = bus.mem_valid & is_wr & sel_data & bus.mem_wstrb[0];
        fifo_empty = count_q == '0;
        fifo_full  = count_q == (aw+1)'(fifo_depth);
        busy       = state_q != IDLE;
        pop        = ~busy & ~fifo_empty;
        // a stalled write retries every cycle; it may land in the same cycle the shifter frees a slot
        push_req   = pend_q | data_wr;
        push       = push_req & (~fifo_full | pop);
        push_data  = pend_q ? pend_data_q : bus.mem_wdata[7:0];
        pend_d     = push_req & ~push;
        count_d    = count_q + (aw+1)'(push) - (aw+1)'(pop);
        rd_val     = sel_data ? {29'b0, fifo_full, fifo_empty, busy} : sel_irq ? {31'b0, irq_en_q} : 32'b0;
        ready_d    = push | (bus.mem_valid & ~data_wr);
        rdata_d    = (bus.mem_valid & ~is_wr) ? rd_val : 32'b0;
        irq_en_d   = (bus.mem_valid & is_wr & sel_irq) ? bus.mem_wdata[0] : irq_en_q;
        irq_d      = irq_en_q & fifo_empty & ~busy;
        cnt_last   = cnt_q == cw'(clk_divider_bit - 1);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            rd_ptr_q    <= pop ? rd_ptr_q + aw'(1) : rd_ptr_q;
            wr_ptr_q    <= push ? wr_ptr_q + aw'(1) : wr_ptr_q;
            count_q     <= count_d;
            pend_q      <= pend_d;
            pend_data_q <= push_data;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= push_data;
    end
    // tx is registered alongside the state so each level lasts exactly clk_divider_bit cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= ~pop;
                    if (pop) begin
                        state_q <= START;
                        shift_q <= fifo_q[rd_ptr_q];
                        cnt_q   <= '0;
                    end
                end
                START: begin
                    cnt_q <= cnt_last ? '0 : cnt_q + cw'(1);
                    if (cnt_last) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    cnt_q <= cnt_last ? '0 : cnt_q + cw'(1);
                    if (cnt_last) begin
                        idx_q   <= idx_q + 3'd1;
                        state_q <= (idx_q == 3'd7) ? STOP : DATA;
                        tx_q    <= (idx_q == 3'd7) ? 1'b1 : shift_q[idx_q + 3'd1];
                    end
                end
                STOP: begin
                    cnt_q   <= cnt_last ? '0 : cnt_q + cw'(1);
                    state_q <= cnt_last ? IDLE : STOP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign tx_o          = tx_q;
    assign irq_o         = irq_q;
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Memory-mapped UART transmitter peripheral at uart_tx_base_addr (mask 0xF), IRQ control register at uart_tx_irq_addr (base+0x8).
- Accepts bytes from the CPU data bus into a small FIFO and serialises them 8N1, LSB first, on tx.
- Bit timing comes from the clk_divider_bit system constant (cpu_freq / baudrate).
- Raises a level interrupt when enabled and transmission has fully drained.

Parameters:
- clk_divider_bit, 8680, clock cycles per UART bit (cpu_freq/baudrate); must be >= 2.
- fifo_depth, 4, transmit FIFO entries; power of two, >= 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- mem_valid  in  1  single-cycle request strobe.
- mem_addr  in  32  byte address; only mem_addr[3:0] decoded (0x0 data/status, 0x8 irq).
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte strobes; nonzero = write, zero = read.
- mem_rdata  out  32  read data, valid when mem_ready=1.
- mem_ready  out  1  single-cycle response strobe.
- tx  out  1  serial output, idle high.
- irq  out  1  transmit-complete interrupt (level).

Behaviour:
- Reset (async, reset=0): tx=1, irq=0, mem_ready=0, mem_rdata=0, FIFO empty, irq_enable=0, shifter IDLE, all counters 0.
- Request capture: on mem_valid=1, addr/wdata/wstrb are latched into a pending slot. Requester issues no new request until mem_ready.
- Write 0x0 (mem_wstrb[0]=1): pushes mem_wdata[7:0] to the FIFO.
  - FIFO not full: mem_ready=1 exactly one cycle after mem_valid.
  - FIFO full: write held pending; pushed and acknowledged the cycle after the shifter pops an entry.
  - A pop and a push in the same cycle are both legal; count is unchanged.
- Read 0x0: mem_rdata = {29'b0, fifo_full, fifo_empty, busy}; latency 1 cycle.
  - busy = shifter not IDLE.
- Write 0x8: irq_enable <= mem_wdata[0]; ready after 1 cycle.
- Read 0x8: mem_rdata = {31'b0, irq_enable}.
- Other offsets: reads return 0, writes are ignored; ready after 1 cycle. Never hangs.
- mem_ready is a one-cycle pulse; mem_rdata returns to 0 when mem_ready=0.
- Shifter FSM, states IDLE, START, DATA, STOP; a bit counter 0..clk_divider_bit-1 and an index 0..7.
  - IDLE: tx=1. If FIFO non-empty, pop the head into the shift register, go to START, and clear the counter.
  - START: tx=0 for clk_divider_bit cycles, then go to DATA with index=0.
  - DATA: tx=shift[index] for clk_divider_bit cycles per bit. After index 7 completes, go to STOP.
  - STOP: tx=1 for clk_divider_bit cycles, then go to IDLE.
  - From IDLE with FIFO non-empty, START begins the next cycle, so back-to-back frames have exactly a 1-cycle IDLE gap.
- Frame length: 10*clk_divider_bit cycles (+1 cycle IDLE).
- The first start-bit falling edge occurs 2 cycles after the accepting mem_valid for an empty FIFO: push in cycle 1, pop to START in cycle 2.
- FIFO: circular pointers of log2(fifo_depth) bits that wrap modulo depth, plus a count of 0..fifo_depth.
  - full when count==fifo_depth; empty when count==0.
- irq = irq_enable & fifo_empty & ~busy, registered, 1-cycle lag.
  - Clearing irq_enable drops irq the following cycle.
  - Pushing new data drops irq once the push is visible.
- Reset mid-frame: tx returns to 1 immediately (asynchronously); FIFO contents and any pending write are discarded.

Test Plan:
- Reset with clk_divider_bit=4: hold reset low 5 cycles -> tx=1, irq=0, mem_ready=0; read 0x0 after release -> 0x2 (empty, not busy).
- Single byte: write 0x0 data 0xA5 -> mem_ready 1 cycle later; tx sequence 0,1,0,1,0,0,1,0,1,1 with each level held 4 cycles; read 0x0 during frame -> 0x3 (busy, empty); after stop, 0x2.
- Full/stall at fifo_depth=4: write 6 bytes 0x01..0x06 back-to-back -> first 5 acked promptly (1 in shifter + 4 in FIFO); 6th ack withheld until 0x01's frame ends (41 cycles after its pop); all six bytes appear in order, with 1-cycle gaps between frames.
- Interrupt: write 0x8 = 1 with FIFO empty -> irq=1 within 2 cycles; write byte 0x55 -> irq=0 until frame ends, then 1; write 0x8 = 0 -> irq=0 next cycle.
- Unmapped access: read 0x4 -> mem_rdata=0, mem_ready after 1 cycle; write 0xC = 0xFF -> no FIFO push, tx stays 1.
- Reset mid-frame: assert reset during DATA bit 3 of 0x0F with 2 bytes queued -> tx=1 asynchronously; after release, tx stays 1 and status reads 0x2.
